pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Drives the enable and bubble-insert inputs of every pipeline register and the PC register.
- Resolves load-use hazards, taken-branch flushes, and instruction/data memory stalls, and drains the pipe on HALT.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 3, width of register specifiers.
- DRAIN_CYCLES, 3, cycles after HALT leaves ID until the pipe is empty (EX, MEM, WB).
- STALL_CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_ADDR_W  source register A of the instruction in ID.
- id_rt  in  REG_ADDR_W  source register B of the instruction in ID.
- id_rs_used  in  1  ID instruction reads id_rs.
- id_rt_used  in  1  ID instruction reads id_rt.
- ex_memrd  in  1  the instruction in EX is a load.
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX.
- br_taken_ex  in  1  branch/jump resolved taken in EX this cycle.
- imem_stall  in  1  instruction memory not ready this cycle.
- dmem_stall  in  1  data memory not ready this cycle.
- halt_id  in  1  the instruction in ID is HALT.
- en_pc  out  1  PC register load enable.
- en_ifid, en_idex, en_exmem, en_memwb  out  1 each  pipeline register load enables.
- flush_ifid, flush_idex, flush_memwb  out  1 each  load a NOP bubble instead of the data. The matching enable is always 1 whenever a flush is 1.
- halted  out  1  processor halted.
- stall_cnt  out  STALL_CNT_W  count of RUN cycles with en_pc=0.

Behaviour:
- States: RUN, DRAIN, HALTED. A down-counter drain_cnt (clog2(DRAIN_CYCLES+1) bits) is active in DRAIN.
- Reset:
  - While rst=1, all en_*=0, all flush_*=0, halted=0.
  - On the edge: state=RUN, drain_cnt=0, stall_cnt=0.
  - Reset mid-DRAIN or in HALTED returns to RUN the next cycle.
- Outputs are combinational from state and the current inputs. No added latency.
- RUN: the first matching rule below applies. The default is all en=1, all flush=0.
  - 1. dmem_stall=1: en_pc, en_ifid, en_idex, en_exmem=0; en_memwb=1, flush_memwb=1 (bubble into WB, so there is no duplicate writeback).
  - 2. br_taken_ex=1: all en=1; flush_ifid=1, flush_idex=1 (the two wrong-path instructions are squashed). Branch beats load-use and imem_stall.
  - 3. Load-use: ex_memrd & ((id_rs_used & id_rs==ex_rd) | (id_rt_used & id_rt==ex_rd)). Outputs: en_pc=0, en_ifid=0, flush_idex=1. EX/MEM and MEM/WB advance. Beats imem_stall.
  - 4. imem_stall=1: en_pc=0; en_ifid=1 with flush_ifid=1. Later stages advance.
- RUN to DRAIN:
  - Occurs when halt_id=1 and rules 1-3 are all inactive, i.e. HALT advances into EX. imem_stall is irrelevant.
  - On the transition, drain_cnt loads DRAIN_CYCLES. The current cycle follows the RUN rules.
- DRAIN:
  - en_pc=0; en_ifid=1 with flush_ifid=1; en_idex=1 with flush_idex=1.
  - If dmem_stall=1, rule 1 outputs apply instead.
  - drain_cnt decrements only on cycles with dmem_stall=0. The transition DRAIN to HALTED happens on the edge where drain_cnt==1 and dmem_stall=0.
  - All other inputs are ignored in DRAIN, including br_taken_ex and halt_id.
- HALTED: all en=0, all flush=0, halted=1. Exit only via rst.
- stall_cnt:
  - +1 on each RUN cycle with en_pc=0. This covers rules 1, 3 and 4, but not rule 2.
  - Saturates at all-ones. Frozen in DRAIN and HALTED.
- Register-0 handling: no special case. A comparison match on register 0 still stalls, which is conservative and correct.

Test Plan:
- Load-use: ex_memrd=1, ex_rd=3, id_rs=3, id_rs_used=1 for one cycle -> en_pc=0, en_ifid=0, flush_idex=1, en_exmem=en_memwb=1; stall_cnt 0->1.
- Same load-use inputs with id_rs_used=0, id_rt=3, id_rt_used=0 -> no stall; all en=1, flush=0.
- br_taken_ex=1 together with a load-use match and imem_stall=1 -> all en=1, flush_ifid=flush_idex=1; stall_cnt unchanged.
- dmem_stall=1 for 4 cycles together with br_taken_ex=1 -> 4 cycles of en_pc..en_exmem=0, en_memwb=1, flush_memwb=1; stall_cnt +4; the branch flush appears on the 5th cycle.
- HALT: halt_id=1 in a clean cycle -> DRAIN; dmem_stall=1 for 1 of the next cycles -> halted=1 after exactly 4 cycles, all en=0. Then rst=1 for one cycle -> RUN, halted=0, stall_cnt=0.
- Saturation: force STALL_CNT_W=4, hold imem_stall=1 for 20 cycles -> stall_cnt reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves hazards,
// drains on HALT and counts stall cycles.
module pipe_stall_ctrl #(
  parameter int unsigned REG_ADDR_W   = 3,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_rs_used,
  input  logic                   id_rt_used,
  input  logic                   ex_memrd,
  input  logic [REG_ADDR_W-1:0]  ex_rd,
  input  logic                   br_taken_ex,
  input  logic                   imem_stall,
  input  logic                   dmem_stall,
  input  logic                   halt_id,
  output logic                   en_pc,
  output logic                   en_ifid,
  output logic                   en_idex,
  output logic                   en_exmem,
  output logic                   en_memwb,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   flush_memwb,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t             state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               load_use_c;
  logic               go_drain_c;

  // Load in EX writes a register the ID instruction is about to read.
  always_comb begin
    load_use_c = ex_memrd &
                 ((id_rs_used & (id_rs == ex_rd)) | (id_rt_used & (id_rt == ex_rd)));
    go_drain_c = (state == S_RUN) & halt_id & ~dmem_stall & ~br_taken_ex & ~load_use_c;
  end

  // Enables and bubbles are combinational so hazards resolve in the same cycle.
  always_comb begin
    en_pc       = 1'b0;
    en_ifid     = 1'b0;
    en_idex     = 1'b0;
    en_exmem    = 1'b0;
    en_memwb    = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_memwb = 1'b0;
    halted      = 1'b0;
    if (!rst) begin
      case (state)
        S_RUN: begin
          en_pc    = 1'b1;
          en_ifid  = 1'b1;
          en_idex  = 1'b1;
          en_exmem = 1'b1;
          en_memwb = 1'b1;
          if (dmem_stall) begin
            en_pc       = 1'b0;
            en_ifid     = 1'b0;
            en_idex     = 1'b0;
            en_exmem    = 1'b0;
            flush_memwb = 1'b1;
          end else if (br_taken_ex) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (load_use_c) begin
            en_pc      = 1'b0;
            en_ifid    = 1'b0;
            flush_idex = 1'b1;
          end else if (imem_stall) begin
            en_pc      = 1'b0;
            flush_ifid = 1'b1;
          end
        end
        S_DRAIN: begin
          en_memwb = 1'b1;
          if (dmem_stall) begin
            flush_memwb = 1'b1;
          end else begin
            en_ifid    = 1'b1;
            en_idex    = 1'b1;
            en_exmem   = 1'b1;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end
        end
        S_HALTED: halted = 1'b1;
        default: ;
      endcase
    end
  end

  // Sequencer state, drain countdown and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (!en_pc && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
          if (go_drain_c) begin
            state     <= S_DRAIN;
            drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
          end
        end
        S_DRAIN: begin
          if (!dmem_stall) begin
            drain_cnt <= drain_cnt - DRAIN_W'(1);
            if (drain_cnt == DRAIN_W'(1))
              state <= S_HALTED;
          end
        end
        S_HALTED: ;
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios plus random traffic against
// a rule-level reference model.
module tb_pipe_stall_ctrl;

  localparam int unsigned RW = 3;
  localparam int unsigned DC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, id_rs_used, id_rt_used, ex_memrd, br_taken_ex;
  logic          imem_stall, dmem_stall, halt_id;
  logic [RW-1:0] id_rs, id_rt, ex_rd;

  logic        en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic        flush_ifid, flush_idex, flush_memwb, halted;
  logic [15:0] stall_cnt;

  logic        s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb;
  logic        s_flush_ifid, s_flush_idex, s_flush_memwb, s_halted;
  logic [3:0]  s_stall_cnt;

  logic [8:0] obs, obs_s;
  assign obs   = {en_pc, en_ifid, en_idex, en_exmem, en_memwb,
                  flush_ifid, flush_idex, flush_memwb, halted};
  assign obs_s = {s_en_pc, s_en_ifid, s_en_idex, s_en_exmem, s_en_memwb,
                  s_flush_ifid, s_flush_idex, s_flush_memwb, s_halted};

  pipe_stall_ctrl #(.REG_ADDR_W(RW), .DRAIN_CYCLES(DC), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .ex_memrd(ex_memrd), .ex_rd(ex_rd),
    .br_taken_ex(br_taken_ex), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .halt_id(halt_id), .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .flush_memwb(flush_memwb), .halted(halted),
    .stall_cnt(stall_cnt));

  pipe_stall_ctrl #(.REG_ADDR_W(RW), .DRAIN_CYCLES(DC), .STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .ex_memrd(ex_memrd), .ex_rd(ex_rd),
    .br_taken_ex(br_taken_ex), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .halt_id(halt_id), .en_pc(s_en_pc), .en_ifid(s_en_ifid), .en_idex(s_en_idex),
    .en_exmem(s_en_exmem), .en_memwb(s_en_memwb), .flush_ifid(s_flush_ifid),
    .flush_idex(s_flush_idex), .flush_memwb(s_flush_memwb), .halted(s_halted),
    .stall_cnt(s_stall_cnt));

  int passed = 0;
  int total  = 0;

  // Reference model: plain flags plus an unbounded stall tally.
  bit m_drain, m_halt;
  int m_left, m_cnt;

  function automatic bit load_use();
    return ex_memrd && ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
  endfunction

  // {en_pc,en_ifid,en_idex,en_exmem,en_memwb,flush_ifid,flush_idex,flush_memwb,halted}
  function automatic logic [8:0] exp_outs();
    if (rst)        return 9'b000000000;
    if (m_halt)     return 9'b000000001;
    if (dmem_stall) return 9'b000010010;
    if (m_drain)    return 9'b011111100;
    if (br_taken_ex) return 9'b111111100;
    if (load_use()) return 9'b001110100;
    if (imem_stall) return 9'b011111000;
    return 9'b111110000;
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (m_cnt > 65535) ? 16'hffff : 16'(m_cnt);
  endfunction

  function automatic logic [3:0] exp_cnt4();
    return (m_cnt > 15) ? 4'hf : 4'(m_cnt);
  endfunction

  // Advance the model with the pre-edge inputs, then clock the DUTs.
  task automatic tick();
    logic [8:0] e;
    e = exp_outs();
    if (rst) begin
      m_drain = 0; m_halt = 0; m_left = 0; m_cnt = 0;
    end else if (m_halt) begin
      m_halt = 1;
    end else if (m_drain) begin
      if (!dmem_stall) begin
        m_left--;
        if (m_left == 0) begin m_drain = 0; m_halt = 1; end
      end
    end else begin
      if (!e[8]) m_cnt++;
      if (halt_id && !dmem_stall && !br_taken_ex && !load_use()) begin
        m_drain = 1; m_left = DC;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0; id_rs_used = 0; id_rt_used = 0;
    ex_memrd = 0; br_taken_ex = 0; imem_stall = 0; dmem_stall = 0; halt_id = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); #1;
    total++;
    if (obs !== exp_outs()) $display("FAIL reset_outs: got %b want %b", obs, exp_outs());
    else passed++;
    tick();
    rst = 0; #1;
    total++;
    if (obs !== exp_outs() || stall_cnt !== 16'd0)
      $display("FAIL reset_release: outs %b want %b cnt %0d want 0", obs, exp_outs(), stall_cnt);
    else passed++;
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_memrd = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1; #1;
    total++;
    if (obs !== exp_outs()) $display("FAIL load_use_outs: got %b want %b", obs, exp_outs());
    else passed++;
    tick();
    total++;
    if (stall_cnt !== exp_cnt16()) $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, exp_cnt16());
    else passed++;
    id_rs_used = 0; id_rt = 3; id_rt_used = 0; #1;
    total++;
    if (obs !== exp_outs()) $display("FAIL no_use_outs: got %b want %b", obs, exp_outs());
    else passed++;
    tick();
  endtask

  task automatic test_branch_priority();
    clear_inputs();
    ex_memrd = 1; ex_rd = 5; id_rt = 5; id_rt_used = 1; imem_stall = 1; br_taken_ex = 1; #1;
    total++;
    if (obs !== exp_outs()) $display("FAIL branch_prio_outs: got %b want %b", obs, exp_outs());
    else passed++;
    tick();
    total++;
    if (stall_cnt !== exp_cnt16()) $display("FAIL branch_prio_cnt: got %0d want %0d", stall_cnt, exp_cnt16());
    else passed++;
  endtask

  task automatic test_dmem_branch();
    logic [15:0] start;
    clear_inputs();
    start = stall_cnt;
    for (int i = 0; i < 5; i++) begin
      dmem_stall = (i < 4); br_taken_ex = 1; #1;
      total++;
      if (obs !== exp_outs()) $display("FAIL dmem_branch_c%0d: got %b want %b", i, obs, exp_outs());
      else passed++;
      tick();
    end
    total++;
    if (stall_cnt !== exp_cnt16() || stall_cnt !== start + 16'd4)
      $display("FAIL dmem_branch_cnt: got %0d want %0d", stall_cnt, start + 16'd4);
    else passed++;
  endtask

  task automatic test_halt();
    int n;
    logic [15:0] frozen;
    clear_inputs();
    halt_id = 1; #1;
    total++;
    if (obs !== exp_outs()) $display("FAIL halt_enter: got %b want %b", obs, exp_outs());
    else passed++;
    tick();
    frozen = stall_cnt;
    halt_id = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      dmem_stall = (i == 1); br_taken_ex = (i == 2); halt_id = (i == 2); #1;
      total++;
      if (obs !== exp_outs()) $display("FAIL halt_drain_c%0d: got %b want %b", i, obs, exp_outs());
      else passed++;
      if (halted) break;
      tick();
      n++;
    end
    total++;
    if (n != 4 || halted !== 1'b1 || stall_cnt !== frozen)
      $display("FAIL halt_latency: cycles %0d want 4, halted %b, cnt %0d want %0d", n, halted, stall_cnt, frozen);
    else passed++;
    clear_inputs();
    rst = 1; tick(); rst = 0; #1;
    total++;
    if (obs !== exp_outs() || halted !== 1'b0 || stall_cnt !== 16'd0)
      $display("FAIL halt_reset: outs %b want %b cnt %0d want 0", obs, exp_outs(), stall_cnt);
    else passed++;
  endtask

  task automatic test_saturation();
    clear_inputs();
    rst = 1; tick(); rst = 0;
    imem_stall = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++;
      if (obs_s !== exp_outs() || s_stall_cnt !== exp_cnt4())
        $display("FAIL sat_c%0d: outs %b want %b cnt %0d want %0d", i, obs_s, exp_outs(), s_stall_cnt, exp_cnt4());
      else passed++;
      tick();
    end
    total++;
    if (s_stall_cnt !== 4'd15) $display("FAIL sat_final: got %0d want 15", s_stall_cnt);
    else passed++;
    imem_stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) < 2) || (m_halt && $urandom_range(0, 3) == 0);
      id_rs       = RW'($urandom);
      id_rt       = RW'($urandom);
      ex_rd       = RW'($urandom);
      id_rs_used  = $urandom_range(0, 1) == 1;
      id_rt_used  = $urandom_range(0, 1) == 1;
      ex_memrd    = $urandom_range(0, 2) == 0;
      br_taken_ex = $urandom_range(0, 6) == 0;
      imem_stall  = $urandom_range(0, 4) == 0;
      dmem_stall  = $urandom_range(0, 6) == 0;
      halt_id     = $urandom_range(0, 19) == 0;
      #1;
      total++;
      if (obs !== exp_outs() || stall_cnt !== exp_cnt16() || s_stall_cnt !== exp_cnt4())
        $display("FAIL random_c%0d: outs %b want %b cnt %0d/%0d want %0d/%0d",
                 i, obs, exp_outs(), stall_cnt, s_stall_cnt, exp_cnt16(), exp_cnt4());
      else passed++;
      tick();
    end
    rst = 0;
  endtask

  initial begin
    m_drain = 0; m_halt = 0; m_left = 0; m_cnt = 0;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_dmem_branch();
    test_halt();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
